// File: rtl/mult_pkg.sv
// mult_pkg: shared mode constants, product type and stage-count helper for pipelined_array_multiplier.
package mult_pkg;
  localparam int MAX_WIDTH = 64;
  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED = 1'b1;
  typedef logic [2*MAX_WIDTH-1:0] prod_t;
  function automatic int nstages(input int width, input int rows);
    return width / rows;
  endfunction
endpackage

// File: rtl/mult_row_stage.sv
// mult_row_stage: one accumulation stage, adds rows FIRST_ROW..FIRST_ROW+ROWS_PER_STAGE-1 to the running sum.
// With MULT_PARITY_OUT_EN the unregistered next sum is exported so the top can register its parity.
module mult_row_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROWS_PER_STAGE = 2,
  parameter int FIRST_ROW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               valid_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [2*WIDTH-1:0] b_ext_i,
  input  logic [2*WIDTH-1:0] sum_i,
  output logic               valid_o,
  output logic               signed_o,
  output logic [WIDTH-1:0]   a_o,
  output logic [2*WIDTH-1:0] b_ext_o,
  output logic [2*WIDTH-1:0] sum_o
`ifdef MULT_PARITY_OUT_EN
  ,
  output logic [2*WIDTH-1:0] sum_d_o
`endif
);
  logic               valid_q, signed_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] b_ext_q, sum_q, sum_d, row;
  // In signed mode the top row carries weight -2^(WIDTH-1), so it is subtracted.
  always_comb begin
    sum_d = sum_i;
    row = '0;
    for (int r = FIRST_ROW; r < FIRST_ROW + ROWS_PER_STAGE; r++) begin
      row = a_i[r] ? b_ext_i << r : '0;
      sum_d = (signed_i == MODE_SIGNED && r == WIDTH - 1) ? sum_d - row : sum_d + row;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      signed_q <= 1'b0;
      a_q      <= '0;
      b_ext_q  <= '0;
      sum_q    <= '0;
    end else if (en_i) begin
      valid_q  <= valid_i;
      signed_q <= signed_i;
      a_q      <= a_i;
      b_ext_q  <= b_ext_i;
      sum_q    <= sum_d;
    end
  end
  assign valid_o  = valid_q;
  assign signed_o = signed_q;
  assign a_o      = a_q;
  assign b_ext_o  = b_ext_q;
  assign sum_o    = sum_q;
`ifdef MULT_PARITY_OUT_EN
  assign sum_d_o  = sum_d;
`endif
endmodule

// File: rtl/pipelined_array_multiplier.sv
// pipelined_array_multiplier: WIDTH x WIDTH signed/unsigned array multiplier, ROWS_PER_STAGE rows per stage.
// Define MULT_PARITY_OUT_EN to add the registered y_parity output (XOR of y).
module pipelined_array_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y
`ifdef MULT_PARITY_OUT_EN
  ,
  output logic               y_parity
`endif
);
  localparam int NSTAGES = nstages(WIDTH, ROWS_PER_STAGE);
  localparam int PW = 2 * WIDTH;
  if (WIDTH < 2 || WIDTH > MAX_WIDTH || WIDTH % ROWS_PER_STAGE != 0) begin : g_bad_cfg
    $error("pipelined_array_multiplier: WIDTH must be 2..64 and a multiple of ROWS_PER_STAGE");
  end
  logic             en, v0_q, sg0_q;
  logic [WIDTH-1:0] a0_q;
  logic [PW-1:0]    b0_q, b0_d;
  logic             v_s   [NSTAGES+1];
  logic             sg_s  [NSTAGES+1];
  logic [WIDTH-1:0] a_s   [NSTAGES+1];
  logic [PW-1:0]    b_s   [NSTAGES+1];
  logic [PW-1:0]    sum_s [NSTAGES+1];
  logic             unused_tail;
  // A single enable stalls the whole pipe whenever the output is held.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b0_d     = is_signed == MODE_UNSIGNED ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q  <= 1'b0;
      sg0_q <= 1'b0;
      a0_q  <= '0;
      b0_q  <= '0;
    end else if (en) begin
      v0_q  <= in_valid;
      sg0_q <= is_signed;
      a0_q  <= a;
      b0_q  <= b0_d;
    end
  end
  assign v_s[0]   = v0_q;
  assign sg_s[0]  = sg0_q;
  assign a_s[0]   = a0_q;
  assign b_s[0]   = b0_q;
  assign sum_s[0] = '0;
`ifdef MULT_PARITY_OUT_EN
  logic [PW-1:0] nxt_s [1:NSTAGES];
  logic          parity_q;
`endif
  for (genvar k = 1; k <= NSTAGES; k++) begin : g_stage
    mult_row_stage #(
      .WIDTH          (WIDTH),
      .ROWS_PER_STAGE (ROWS_PER_STAGE),
      .FIRST_ROW      ((k - 1) * ROWS_PER_STAGE)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (en),
      .valid_i  (v_s[k-1]),
      .signed_i (sg_s[k-1]),
      .a_i      (a_s[k-1]),
      .b_ext_i  (b_s[k-1]),
      .sum_i    (sum_s[k-1]),
      .valid_o  (v_s[k]),
      .signed_o (sg_s[k]),
      .a_o      (a_s[k]),
      .b_ext_o  (b_s[k]),
      .sum_o    (sum_s[k])
`ifdef MULT_PARITY_OUT_EN
      ,
      .sum_d_o  (nxt_s[k])
`endif
    );
  end
  assign out_valid   = v_s[NSTAGES];
  assign y           = sum_s[NSTAGES];
  assign unused_tail = ^{sg_s[NSTAGES], a_s[NSTAGES], b_s[NSTAGES]};
`ifdef MULT_PARITY_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else if (en) parity_q <= ^nxt_s[NSTAGES];
  end
  assign y_parity = parity_q;
`endif
endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// tb_pipelined_array_multiplier: directed and randomized checks of an 8-bit/RPS2 and a 48-bit/RPS4 instance.
module tb_pipelined_array_multiplier;
  import mult_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic rst8_n, iv8, ir8, s8, ov8, or8;
  logic [7:0] a8, b8;
  logic [15:0] y8;
  logic rst48_n, iv48, ir48, s48, ov48, or48;
  logic [47:0] a48, b48;
  logic [95:0] y48;
`ifdef MULT_PARITY_OUT_EN
  logic p8, p48;
`endif
  prod_t q8[$], q48[$];
  prod_t e8, e48;
  int run8 = 0, max8 = 0;
  logic done48 = 1'b0;

  pipelined_array_multiplier #(.WIDTH(8), .ROWS_PER_STAGE(2)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .y(y8)
`ifdef MULT_PARITY_OUT_EN
    , .y_parity(p8)
`endif
  );
  pipelined_array_multiplier #(.WIDTH(48), .ROWS_PER_STAGE(4)) u_dut48 (
    .clk(clk), .rst_n(rst48_n), .in_valid(iv48), .in_ready(ir48), .a(a48), .b(b48),
    .is_signed(s48), .out_valid(ov48), .out_ready(or48), .y(y48)
`ifdef MULT_PARITY_OUT_EN
    , .y_parity(p48)
`endif
  );

  task automatic check(input string tag, input prod_t got, input prod_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: extend both operands to the full width, multiply, keep 2*w bits.
  function automatic prod_t ref_mul(input prod_t a, input prod_t b, input logic s, input int w);
    prod_t ea, eb, lo;
    lo = (prod_t'(1) << w) - 1;
    ea = a & lo;
    eb = b & lo;
    if (s && ea[w-1]) ea = ea | ~lo;
    if (s && eb[w-1]) eb = eb | ~lo;
    return (ea * eb) & ((prod_t'(1) << (2 * w)) - 1);
  endfunction

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s, input prod_t e);
    int g;
    logic acc;
    g = 0;
    acc = 1'b0;
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
    while (!acc && g < 100) begin
      @(negedge clk) acc = ir8;
      @(posedge clk) #1;
      g++;
    end
    if (!acc) check("acc8", prod_t'(acc), prod_t'(1));
    else q8.push_back(e);
    iv8 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ov8 && or8) begin
      run8++;
      if (run8 > max8) max8 = run8;
      if (q8.size() == 0) check("spur8", prod_t'(ov8), prod_t'(0));
      else begin
        e8 = q8.pop_front();
        check("y8", prod_t'(y8), e8);
`ifdef MULT_PARITY_OUT_EN
        check("par8", prod_t'(p8), prod_t'(^e8));
`endif
      end
    end else run8 = 0;
  end

  always @(negedge clk) begin
    if (ov48 && or48) begin
      if (q48.size() == 0) check("spur48", prod_t'(ov48), prod_t'(0));
      else begin
        e48 = q48.pop_front();
        check("y48", prod_t'(y48), e48);
`ifdef MULT_PARITY_OUT_EN
        check("par48", prod_t'(p48), prod_t'(^e48));
`endif
      end
    end
  end

  initial begin
    int acc_n, cyc;
    rst48_n = 1'b0; iv48 = 1'b0; or48 = 1'b1; a48 = '0; b48 = '0; s48 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst48_n = 1'b1;
    acc_n = 0;
    cyc = 0;
    while (acc_n < 1000 && cyc < 20000) begin
      or48 = ($urandom_range(3) != 0);
      iv48 = ($urandom_range(3) != 0);
      a48 = 48'({$urandom(), $urandom()});
      b48 = 48'({$urandom(), $urandom()});
      s48 = 1'($urandom());
      if (acc_n == 0) begin a48 = 48'h8000_0000_0000; b48 = 48'h8000_0000_0000; s48 = 1'b1; end
      if (acc_n == 1) begin a48 = '1; b48 = '1; s48 = 1'b0; end
      if (acc_n == 2) begin a48 = '1; b48 = 48'h8000_0000_0000; s48 = 1'b1; end
      if (acc_n == 3) begin a48 = 48'h7FFF_FFFF_FFFF; b48 = 48'h8000_0000_0000; s48 = 1'b1; end
      @(negedge clk);
      if (iv48 && ir48) begin
        q48.push_back(ref_mul(prod_t'(a48), prod_t'(b48), s48, 48));
        acc_n++;
      end
      @(posedge clk) #1;
      cyc++;
    end
    check("acc48", prod_t'(acc_n), prod_t'(1000));
    iv48 = 1'b0;
    or48 = 1'b1;
    cyc = 0;
    while (q48.size() != 0 && cyc < 100) begin
      @(posedge clk) #1;
      cyc++;
    end
    check("drain48", prod_t'(q48.size()), prod_t'(0));
    done48 = 1'b1;
  end

  initial begin
    int n, stale;
    logic [7:0] ra, rb;
    logic rs;
    rst8_n = 1'b0; iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; s8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov", prod_t'(ov8), prod_t'(0));
    check("rst_y", prod_t'(y8), prod_t'(0));
    rst8_n = 1'b1;
    #1 check("rst_ir", prod_t'(ir8), prod_t'(1));
    // latency from accept to out_valid
    send8(8'hFF, 8'hFF, 1'b0, prod_t'(16'hFE01));
    n = 1;
    while (!ov8 && n < 20) begin
      @(posedge clk) #1;
      n++;
    end
    check("lat", prod_t'(n), prod_t'(5));
    check("y_ff", prod_t'(y8), prod_t'(16'hFE01));
    repeat (3) @(posedge clk);
    #1;
    send8(8'h80, 8'h80, 1'b1, prod_t'(16'h4000));
    send8(8'hFF, 8'h01, 1'b1, prod_t'(16'hFFFF));
    send8(8'h7F, 8'h80, 1'b1, prod_t'(16'hC080));
    repeat (8) @(posedge clk);
    #1 max8 = 0;
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom()); rb = 8'($urandom()); rs = 1'($urandom());
      send8(ra, rb, rs, ref_mul(prod_t'(ra), prod_t'(rb), rs, 8));
    end
    repeat (8) @(posedge clk);
    #1;
    check("burst_run", prod_t'(max8), prod_t'(8));
    check("burst_q", prod_t'(q8.size()), prod_t'(0));
    // back-pressure: fill the pipe, then keep offering while the output is held
    or8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra = 8'($urandom()); rb = 8'($urandom()); rs = 1'($urandom());
      send8(ra, rb, rs, ref_mul(prod_t'(ra), prod_t'(rb), rs, 8));
    end
    a8 = 8'h5A; b8 = 8'hC3; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ov", prod_t'(ov8), prod_t'(1));
      check("stall_ir", prod_t'(ir8), prod_t'(0));
      check("stall_y", prod_t'(y8), q8[0]);
      @(posedge clk) #1;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("stall_q", prod_t'(q8.size()), prod_t'(0));
    // reset with products in flight
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom()); rb = 8'($urandom()); rs = 1'($urandom());
      send8(ra, rb, rs, ref_mul(prod_t'(ra), prod_t'(rb), rs, 8));
    end
    rst8_n = 1'b0;
    #1;
    check("mid_ov", prod_t'(ov8), prod_t'(0));
    check("mid_y", prod_t'(y8), prod_t'(0));
    q8.delete();
    @(posedge clk) #1 rst8_n = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov8) stale++;
    end
    check("stale", prod_t'(stale), prod_t'(0));
    n = 0;
    while (!done48 && n < 50000) begin
      @(posedge clk);
      n++;
    end
    check("done48", prod_t'(done48), prod_t'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_array_multiplier.md
Name: pipelined_array_multiplier

Overview:
Parametrised successor to the fixed 48-bit pipelined array multiplier. Computes a full 2*WIDTH-bit product of two WIDTH-bit operands, signed or unsigned, selected per transaction. Partial-product rows are accumulated ROWS_PER_STAGE at a time per pipeline stage. Valid/ready handshakes on input and output, with back-pressure stalling the whole pipe. Used as the datapath multiplier in the Ch05 RTL examples and as the timing/area sweep vehicle across widths and depths.

Parameters:
WIDTH, 16, operand width in bits; legal range 2 to 64.
ROWS_PER_STAGE, 2, partial-product rows summed per pipeline stage. WIDTH % ROWS_PER_STAGE must be 0; any other value is an elaboration error.
NSTAGES, WIDTH/ROWS_PER_STAGE, derived and not overridable: number of accumulation stages.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands present.
in_ready  output  1  pipe can accept this cycle.
a  input  WIDTH  multiplicand (row selector).
b  input  WIDTH  multiplier (shifted row value).
is_signed  input  1  1 = two's-complement operands; 0 = unsigned.
out_valid  output  1  y holds a completed product.
out_ready  input  1  consumer accepts y.
y  output  2*WIDTH  product.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: all stage valid bits clear; out_valid=0, y=0, in_ready=1 once rst_n deasserts. Asserting rst_n mid-operation discards every in-flight product; no partial result emerges afterwards.
- Pipe enable: en = !out_valid || out_ready. in_ready = en. Every stage register loads only when en=1; otherwise all stages hold.
- Accept: a transfer occurs when in_valid && in_ready. Stage 0 registers a, b, is_signed and valid=1. If in_valid=0 while en=1, a bubble (valid=0) enters; bubbles advance and never raise out_valid.
- Stage k (1..NSTAGES): adds rows r = (k-1)*ROWS_PER_STAGE .. k*ROWS_PER_STAGE-1 to the running 2*WIDTH sum. It forwards a, b_ext, is_signed and valid to the next stage.
- Row r = a[r] ? (b_ext << r) : 0, with b_ext being b zero-extended (unsigned) or sign-extended (signed) to 2*WIDTH.
- Signed mode: row WIDTH-1 is subtracted instead of added (weight -2^(WIDTH-1)).
- All arithmetic is modulo 2^(2*WIDTH). The result is exact for both modes, including -2^(WIDTH-1) * -2^(WIDTH-1).
- Output: y/out_valid are the stage-NSTAGES registers. Latency is 1+NSTAGES cycles from accept to out_valid when unstalled. Throughput is 1 per cycle.
- Stall: y, out_valid and all stage contents stay stable while out_valid && !out_ready. No product is dropped or duplicated.
- Simultaneous accept and output consume in one cycle is allowed (en=1).
- Products leave in acceptance order.

Optional Feature:
Macro MULT_PARITY_OUT_EN.
- Defined: extra output port y_parity (1 bit) = XOR-reduction of y, registered alongside y. Reset value 0; it holds with y under stall. Used for gate-level sweeps that need a single observable output.
- Undefined: the port is absent, and no parity logic exists.

Decomposition:
- Package mult_pkg: localparam function nstages(width, rows); typedef for the 2*WIDTH-bit product; mode constants MODE_UNSIGNED=0 and MODE_SIGNED=1.
- Sub-module mult_row_stage: one pipeline stage parameterised by WIDTH, ROWS_PER_STAGE and FIRST_ROW. It holds the sum/operand/valid registers and the enable input, and is instantiated NSTAGES times by a generate loop in the top.

Test Plan:
1. WIDTH=8, RPS=2, out_ready=1; accept a=0xFF, b=0xFF, is_signed=0 -> out_valid exactly 5 cycles later, y=0xFE01.
2. Same config, is_signed=1: a=0x80,b=0x80 -> y=0x4000; a=0xFF,b=0x01 -> y=0xFFFF; a=0x7F,b=0x80 -> y=0xC080.
3. Back-to-back burst of 8 random accepts with out_ready=1 -> 8 consecutive out_valid cycles, in order, all matching the reference model.
4. out_ready=0 for 10 cycles while feeding continuously -> in_ready falls once out_valid=1; y holds constant; on release, all queued products drain in order with none lost.
5. Assert rst_n low for 1 cycle with 3 products in flight -> out_valid=0 and y=0 immediately; no stale product appears in the following 10 cycles.
6. WIDTH=48, RPS=4, 1000 random signed/unsigned vectors with random out_ready -> all products match. With MULT_PARITY_OUT_EN defined, y_parity == ^y on every output beat.
